inv_round_key_sequencer: RTL and testbench
==========================================

Name: inv_round_key_sequencer

Overview:
- Supplies AES-128 round keys in reverse order (K10, K9 … K0) for the on-the-fly decryption datapath.
- Inverse counterpart of the forward one-round-per-cycle key update:
  - On key load, expands forward for 10 cycles to reach K10 and caches it.
  - Then steps backward one round per accepted request using the inverse key-schedule relation.
- Sits between the key register interface and the inverse-cipher round engine.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds. Only 10 (AES-128) is supported; any other value is a compile-time error.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous active-high reset
- key_load  input  1  pulse: capture key_in as K0 and start expansion
- key_in  input  128  cipher key K0, big-endian words {w0,w1,w2,w3}
- key_adv  input  1  consumer accepts current round_key and requests the next-lower round
- round_key  output  128  current round key
- round_idx  output  4  index of round_key (10 down to 0)
- key_valid  output  1  round_key/round_idx are valid
- busy  output  1  forward expansion in progress

Behaviour:
- Reset, applied on the clk edge while rst=1 and overriding all other inputs:
  - state=IDLE; cur_key, last_key, round_key = 0; round_idx=0; key_valid=0; busy=0.
- States:
  - IDLE: key_valid=0, busy=0. key_load -> EXPAND.
  - EXPAND: busy=1, key_valid=0.
  - SERVE: key_valid=1, busy=0.
- key_load edge (any state, highest priority after rst):
  - cur_key<=key_in; rnd<=0; state<=EXPAND.
  - Any key_adv in the same cycle is ignored.
- EXPAND, each cycle:
  - cur_key<=fwd(cur_key, rnd+1); rnd<=rnd+1.
  - On the edge where rnd becomes 10: last_key<=result; state<=SERVE.
  - key_valid therefore rises exactly 10 cycles after the key_load edge.
  - key_adv is ignored while busy.
- Forward step fwd(K, r):
  - g = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}
  - w4=w0^g; w5=w1^w4; w6=w2^w5; w7=w3^w6.
- Inverse step inv(K, r), which recovers round r-1 from round r (words w4..w7):
  - w3=w7^w6; w2=w6^w5; w1=w5^w4
  - w0=w4^SubWord(RotWord(w3))^{Rcon[r],24'h0}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Indices 0 and 11-15 are never used; they return 00.
- SERVE:
  - round_key=cur_key, round_idx=rnd.
  - key_adv with rnd>0: cur_key<=inv(cur_key, rnd); rnd<=rnd-1. key_valid stays 1, giving one key per cycle back-to-back.
  - key_adv with rnd==0: wrap; cur_key<=last_key; rnd<=10. This re-arms for the next block under the same key with no re-expansion.
  - key_adv=0: hold all outputs stable.
- Outputs are registered, not combinational from inputs. Only the update logic is combinational, at one S-box layer (4 S-boxes) per cycle.
- rst or key_load during EXPAND or SERVE aborts the current sequence immediately; no partial keys are emitted.

Decomposition:
- Shared package aes_key_pkg:
  - AES_NK=4, AES_NR=10
  - Rcon table function
  - SubWord/RotWord functions (shared S-box table)
  - round-index typedef (4-bit)
- Sub-module inv_round_key_step: combinational inv(K, r), 128-bit in, 4-bit round in, 128-bit out.
- The forward step reuses the existing forward round-key update block, instantiated once.
- Sequencer FSM and registers live in the top module.

Test Plan:
- Reset, then key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy=1 for 10 cycles. Then key_valid=1, round_idx=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- From SERVE, hold key_adv=1 for 10 cycles -> keys stream one per cycle:
  - idx 9 = ac7766f319fadc2128d12941575c006e
  - idx 1 = a0fafe1788542cb123a339392a6c7605
  - idx 0 = 2b7e151628aed2a6abf7158809cf4f3c
- key_adv at idx 0 -> next cycle idx=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, busy stays 0.
- Pulse key_adv during EXPAND, and idle gaps with key_adv=0 in SERVE -> no index change, outputs stable.
- key_load with key 000102030405060708090a0b0c0d0e0f at cycle 5 of EXPAND -> restart. 10 cycles later K10=13111d7fe3944a17f307a78b4d2b30c5.
- rst asserted mid-SERVE -> next edge: key_valid=0, round_key=0, round_idx=0, busy=0, state IDLE. key_adv is then ignored.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule constants, round-index type and byte/word helpers.
package aes_key_pkg;

  localparam int unsigned AES_NK = 4;
  localparam int unsigned AES_NR = 10;

  // Round index 0..10 fits in 4 bits.
  typedef logic [3:0] rnd_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Byte b sits at bit offset (255 - b) * 8.
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant; unused indices return zero.
  function automatic logic [7:0] rcon(input rnd_t r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/fwd_round_key_step.sv
// Combinational forward AES-128 round-key update: K(r-1) -> K(r).
module fwd_round_key_step
  import aes_key_pkg::*;
(
  input  logic [127:0] key,
  input  rnd_t         rnd,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3, g, w4, w5, w6, w7;

  // One S-box layer on the rotated last word, then the xor chain.
  always_comb begin
    w0 = key[127:96];
    w1 = key[95:64];
    w2 = key[63:32];
    w3 = key[31:0];
    g  = sub_word(rot_word(w3)) ^ {rcon(rnd), 24'h0};
    w4 = w0 ^ g;
    w5 = w1 ^ w4;
    w6 = w2 ^ w5;
    w7 = w3 ^ w6;
    next_key = {w4, w5, w6, w7};
  end

endmodule

// File: rtl/inv_round_key_step.sv
// Combinational inverse AES-128 round-key update: K(r) -> K(r-1).
module inv_round_key_step
  import aes_key_pkg::*;
(
  input  logic [127:0] key,
  input  rnd_t         rnd,
  output logic [127:0] prev_key
);

  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;

  // Undo the xor chain first; w3 is then available for the S-box layer.
  always_comb begin
    w4 = key[127:96];
    w5 = key[95:64];
    w6 = key[63:32];
    w7 = key[31:0];
    w3 = w7 ^ w6;
    w2 = w6 ^ w5;
    w1 = w5 ^ w4;
    w0 = w4 ^ sub_word(rot_word(w3)) ^ {rcon(rnd), 24'h0};
    prev_key = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/inv_round_key_sequencer.sv
// Supplies AES-128 round keys K10..K0 for the inverse cipher: expands forward once per
// key load, caches K10, then steps backward one round per accepted request.
module inv_round_key_sequencer
  import aes_key_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         key_adv,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy
);

  if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
    $error("inv_round_key_sequencer supports only NUM_ROUNDS = 10 (AES-128)");
  end

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExpand = 2'd1;
  localparam logic [1:0] StServe  = 2'd2;

  localparam rnd_t LastRnd = rnd_t'(NUM_ROUNDS);

  logic [1:0]   state_q, state_d;
  logic [127:0] cur_key_q, cur_key_d;
  logic [127:0] last_key_q, last_key_d;
  rnd_t         rnd_q, rnd_d;
  rnd_t         rnd_inc;
  logic [127:0] fwd_key, inv_key;

  assign rnd_inc = rnd_q + rnd_t'(1);

  fwd_round_key_step u_fwd_step (
    .key      (cur_key_q),
    .rnd      (rnd_inc),
    .next_key (fwd_key)
  );

  inv_round_key_step u_inv_step (
    .key      (cur_key_q),
    .rnd      (rnd_q),
    .prev_key (inv_key)
  );

  // Next-state: key_load restarts from any state; otherwise expand or serve.
  always_comb begin
    state_d    = state_q;
    cur_key_d  = cur_key_q;
    last_key_d = last_key_q;
    rnd_d      = rnd_q;
    if (key_load) begin
      cur_key_d = key_in;
      rnd_d     = '0;
      state_d   = StExpand;
    end else begin
      case (state_q)
        StIdle: ;
        StExpand: begin
          cur_key_d = fwd_key;
          rnd_d     = rnd_inc;
          if (rnd_inc == LastRnd) begin
            last_key_d = fwd_key;
            state_d    = StServe;
          end
        end
        StServe: begin
          if (key_adv) begin
            if (rnd_q != '0) begin
              cur_key_d = inv_key;
              rnd_d     = rnd_q - rnd_t'(1);
            end else begin
              // Re-arm from the cached K10 for the next block.
              cur_key_d = last_key_q;
              rnd_d     = LastRnd;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_key_q  <= '0;
      last_key_q <= '0;
      rnd_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_key_q  <= cur_key_d;
      last_key_q <= last_key_d;
      rnd_q      <= rnd_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    round_key = cur_key_q;
    round_idx = rnd_q;
    key_valid = (state_q == StServe);
    busy      = (state_q == StExpand);
  end

endmodule

// File: tb/tb_inv_round_key_sequencer.sv
// Self-checking bench: directed known-answer vectors plus random load/advance/reset traffic
// compared against a key-schedule-array model.
module tb_inv_round_key_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_adv;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: 0 idle, 1 expanding, 2 serving.
  int           m_mode = 0;
  int           m_cnt  = 0;
  int           m_idx  = 0;
  logic [127:0] m_sched [11];
  logic [7:0]   sb [256];

  always #5 clk = ~clk;

  inv_round_key_sequencer #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_adv   (key_adv),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  // Textbook 44-word key expansion into eleven round keys.
  task automatic build_schedule(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      m_sched[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic model_edge(input logic r, input logic ld, input logic [127:0] k,
                            input logic adv);
    if (r) begin
      m_mode = 0;
      m_idx  = 0;
    end else if (ld) begin
      build_schedule(k);
      m_mode = 1;
      m_cnt  = 0;
    end else if (m_mode == 1) begin
      m_cnt++;
      if (m_cnt == 10) begin
        m_mode = 2;
        m_idx  = 10;
      end
    end else if (m_mode == 2 && adv) begin
      m_idx = (m_idx == 0) ? 10 : m_idx - 1;
    end
  endtask

  task automatic check_all();
    check_eq("busy", 128'(busy), 128'(m_mode == 1));
    check_eq("key_valid", 128'(key_valid), 128'(m_mode == 2));
    if (m_mode == 2) begin
      check_eq("round_idx", 128'(round_idx), 128'(m_idx));
      check_eq("round_key", round_key, m_sched[m_idx]);
    end else if (m_mode == 0) begin
      check_eq("idle_idx", 128'(round_idx), 128'h0);
      check_eq("idle_key", round_key, 128'h0);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [127:0] k, input logic adv);
    rst      = r;
    key_load = ld;
    key_in   = k;
    key_adv  = adv;
    @(posedge clk);
    model_edge(r, ld, k, adv);
    #1;
    check_all();
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k;
    build_sbox();
    rst = 1'b1; key_load = 1'b0; key_in = '0; key_adv = 1'b0;

    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // FIPS-197 key: expansion with key_adv pulses that must be ignored.
    step(1'b0, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0, i[0]);
    check_eq("still_busy", 128'(busy), 128'h1);
    step(1'b0, 1'b0, '0, 1'b0);
    check_eq("kat_k10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_eq("kat_idx10", 128'(round_idx), 128'd10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    check_eq("hold_k10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int i = 10; i > 0; i--) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (i == 10) check_eq("kat_k9", round_key, 128'hac7766f319fadc2128d12941575c006e);
      if (i == 2)  check_eq("kat_k1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
      if (i == 1)  check_eq("kat_k0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    check_eq("wrap_idx", 128'(round_idx), 128'd10);
    check_eq("wrap_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_eq("wrap_busy", 128'(busy), 128'h0);

    // Restart mid-expansion with the FIPS-197 appendix C key.
    step(1'b0, 1'b1, rand_key(), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b0);
    check_eq("restart_k10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset mid-serve, then key_adv must do nothing.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    check_eq("rst_valid", 128'(key_valid), 128'h0);
    check_eq("rst_key", round_key, 128'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, adv;
      r   = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      adv = $urandom_range(0, 1) == 1;
      k   = rand_key();
      step(r, ld, k, adv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
